// File: rtl/boot_copy_ctl.sv
// boot_copy_ctl: boot-image copy sequencer.
// Copies ceil(romsiz/2) words (capped at MAX_WORDS) from the boot ROM into RAM
// through a req/ack write port. It holds the CPU core in reset until the copy finishes.
// Optional feature macro: BOOT_COPY_VERIFY_EN. When it is defined, a read-back
// verify pass runs after the copy and sets the sticky err flag on a mismatch.
module boot_copy_ctl #(
    parameter logic [15:0] DST_BASE  = 16'h0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  rom_adr,
    input  logic [15:0] rom_dat,
    input  logic [15:0] romsiz,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_adr,
    output logic [15:0] mem_wdat,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdat,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIZE,
        ST_RD,
        ST_WR,
        ST_VRD,
        ST_VCMP,
        ST_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [8:0]  r_i, w_i_nxt;
    logic [8:0]  r_n, w_n_nxt;
    logic [7:0]  r_rom_adr;
    logic        r_mem_req, w_mem_req_nxt;
    logic        r_mem_we, w_mem_we_nxt;
    logic [15:0] r_mem_adr, w_mem_adr_nxt;
    logic [15:0] r_mem_wdat, w_mem_wdat_nxt;
    logic        r_cpu_rst, r_busy, r_done;
    logic        w_busy_nxt, w_done_nxt, w_cpu_rst_nxt;
    logic [8:0]  w_i_inc;
    logic [15:0] w_dst_adr;
    logic [16:0] w_words;
    logic [8:0]  w_n_calc;

    // Word count: round odd byte sizes up, then clamp to MAX_WORDS.
    assign w_words  = ({1'b0, romsiz} + 17'd1) >> 1;
    assign w_n_calc = (w_words > 17'(MAX_WORDS)) ? 9'(MAX_WORDS) : w_words[8:0];
    assign w_i_inc  = r_i + 9'd1;
    assign w_dst_adr = DST_BASE + {7'd0, r_i};

`ifdef BOOT_COPY_VERIFY_EN
    logic [15:0] r_rdat, w_rdat_nxt;
    logic        r_err, w_err_nxt;
    assign err = r_err;
`else
    logic w_unused_rdat;
    assign w_unused_rdat = ^mem_rdat;
    assign err = 1'b0;
`endif

    // Next-state and next-output computation; every output is registered below.
    always_comb begin
        w_state_nxt    = r_state;
        w_i_nxt        = r_i;
        w_n_nxt        = r_n;
        w_mem_req_nxt  = r_mem_req;
        w_mem_we_nxt   = r_mem_we;
        w_mem_adr_nxt  = r_mem_adr;
        w_mem_wdat_nxt = r_mem_wdat;
`ifdef BOOT_COPY_VERIFY_EN
        w_rdat_nxt     = r_rdat;
        w_err_nxt      = r_err;
`endif
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_SIZE;
            end
            ST_SIZE: begin
                w_n_nxt     = w_n_calc;
                w_i_nxt     = '0;
                w_state_nxt = (w_n_calc == '0) ? ST_DONE : ST_RD;
            end
            ST_RD: begin
                w_mem_wdat_nxt = rom_dat;
                w_mem_req_nxt  = 1'b1;
                w_mem_we_nxt   = 1'b1;
                w_mem_adr_nxt  = w_dst_adr;
                w_state_nxt    = ST_WR;
            end
            ST_WR: begin
                if (mem_ack) begin
                    w_mem_req_nxt = 1'b0;
                    w_i_nxt       = w_i_inc;
                    if (w_i_inc < r_n) begin
                        w_state_nxt = ST_RD;
                    end else begin
`ifdef BOOT_COPY_VERIFY_EN
                        w_i_nxt     = '0;
                        w_state_nxt = ST_VRD;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end
                end
            end
`ifdef BOOT_COPY_VERIFY_EN
            // VRD spends one cycle raising the registered request, then waits for ack.
            ST_VRD: begin
                if (!r_mem_req) begin
                    w_mem_req_nxt = 1'b1;
                    w_mem_we_nxt  = 1'b0;
                    w_mem_adr_nxt = w_dst_adr;
                end else if (mem_ack) begin
                    w_rdat_nxt    = mem_rdat;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = ST_VCMP;
                end
            end
            ST_VCMP: begin
                if (r_rdat != rom_dat) begin
                    w_err_nxt = 1'b1;
                end
                w_i_nxt     = w_i_inc;
                w_state_nxt = (w_i_inc < r_n) ? ST_VRD : ST_DONE;
            end
`endif
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt    = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
        w_done_nxt    = (w_state_nxt == ST_DONE);
        w_cpu_rst_nxt = (w_state_nxt != ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_i        <= '0;
            r_n        <= '0;
            r_rom_adr  <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_adr  <= DST_BASE;
            r_mem_wdat <= '0;
            r_cpu_rst  <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef BOOT_COPY_VERIFY_EN
            r_rdat     <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_i        <= w_i_nxt;
            r_n        <= w_n_nxt;
            r_rom_adr  <= w_i_nxt[7:0];
            r_mem_req  <= w_mem_req_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_mem_adr  <= w_mem_adr_nxt;
            r_mem_wdat <= w_mem_wdat_nxt;
            r_cpu_rst  <= w_cpu_rst_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
`ifdef BOOT_COPY_VERIFY_EN
            r_rdat     <= w_rdat_nxt;
            r_err      <= w_err_nxt;
`endif
        end
    end

    assign rom_adr  = r_rom_adr;
    assign mem_req  = r_mem_req;
    assign mem_we   = r_mem_we;
    assign mem_adr  = r_mem_adr;
    assign mem_wdat = r_mem_wdat;
    assign cpu_rst  = r_cpu_rst;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_boot_copy_ctl.sv
// Bench for boot_copy_ctl: randomized ROM contents, sizes and RAM latency.
// Expected writes are queued per run and popped by a monitor on each handshake.
module tb_boot_copy_ctl;

    localparam logic [15:0] TB_BASE = 16'hFFF0;
    localparam int unsigned TB_MAXW = 256;
`ifdef BOOT_COPY_VERIFY_EN
    localparam bit TB_VERIFY = 1'b1;
`else
    localparam bit TB_VERIFY = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] adr;
        logic [15:0] dat;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rom_adr;
    logic [15:0] rom_dat;
    logic [15:0] romsiz;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_adr, mem_wdat, mem_rdat;
    logic        cpu_rst, busy, done, err;

    logic [15:0] rom_mem [256];
    logic [15:0] ram [65536];
    int unsigned ack_lat = 0;
    int unsigned r_wait = 0;
    bit          noise_en = 1'b0;
    bit          noise_bit = 1'b0;
    bit          corrupt_en = 1'b0;

    wr_t         sb[$];
    int unsigned wr_cnt = 0, rd_cnt = 0, wr_base = 0, rd_base = 0;
    int unsigned errors = 0, checks = 0;

    logic        p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [15:0] p_adr = '0, p_wdat = '0;

    always #5 clk = ~clk;

    boot_copy_ctl #(.DST_BASE(TB_BASE), .MAX_WORDS(TB_MAXW)) dut (
        .clk(clk), .rst(rst), .rom_adr(rom_adr), .rom_dat(rom_dat), .romsiz(romsiz),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdat(mem_wdat),
        .mem_ack(mem_ack), .mem_rdat(mem_rdat), .cpu_rst(cpu_rst), .busy(busy),
        .done(done), .err(err)
    );

    // Combinational ROM and RAM models; ack arrives after ack_lat wait cycles.
    assign rom_dat  = rom_mem[rom_adr];
    assign mem_ack  = mem_req ? (r_wait >= ack_lat) : noise_bit;
    assign mem_rdat = ram[mem_adr] ^
                      ((corrupt_en && mem_adr == 16'(TB_BASE + 2)) ? 16'h0040 : 16'h0000);

    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) ram[mem_adr] <= mem_wdat;
        if (!mem_req || mem_ack) r_wait <= 0;
        else                     r_wait <= r_wait + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: request stability during waits, scoreboard pop on each accepted access.
    always @(negedge clk) begin
        if (p_req && !p_ack && mem_req) begin
            chk("hold_adr", 32'(mem_adr), 32'(p_adr));
            chk("hold_wdat", 32'(mem_wdat), 32'(p_wdat));
            chk("hold_we", 32'(mem_we), 32'(p_we));
        end
        if (mem_req && mem_ack) begin
            if (mem_we) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_write: adr 0x%0h data 0x%0h, expected none", mem_adr, mem_wdat);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("write_adr", 32'(mem_adr), 32'(e.adr));
                    chk("write_dat", 32'(mem_wdat), 32'(e.dat));
                end
                wr_cnt++;
            end else begin
                chk("read_adr", 32'(mem_adr), 32'(16'(TB_BASE + (rd_cnt - rd_base))));
                rd_cnt++;
            end
        end
        p_req  = mem_req;
        p_ack  = mem_ack;
        p_we   = mem_we;
        p_adr  = mem_adr;
        p_wdat = mem_wdat;
        noise_bit = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_rom_adr"}, 32'(rom_adr), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_adr"}, 32'(mem_adr), 32'(TB_BASE));
        chk({tag, "_mem_wdat"}, 32'(mem_wdat), 32'd0);
        chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Hold reset, load the ROM, and queue the writes a correct copy must make.
    task automatic prep(input logic [15:0] size, input int unsigned lat, input bit pat,
                        output int unsigned n);
        int unsigned w;
        @(negedge clk);
        rst = 1'b1;
        romsiz = size;
        ack_lat = lat;
        for (int k = 0; k < 256; k++)
            rom_mem[k] = pat ? 16'(16'hA500 + k) : 16'($urandom);
        w = (32'(size) + 1) / 2;
        n = (w > TB_MAXW) ? TB_MAXW : w;
        @(negedge clk);
        sb.delete();
        wr_base = wr_cnt;
        rd_base = rd_cnt;
        for (int k = 0; k < int'(n); k++)
            sb.push_back('{adr: 16'(TB_BASE + k), dat: rom_mem[k]});
    endtask

    // Release reset and check completion timing, flags and access counts.
    task automatic finish_run(input string tag, input int unsigned n, input int unsigned lat,
                              input bit chg);
        int unsigned exp_cyc, cyc;
        bit seen, bad;
        exp_cyc = 2 + n * (lat + 2) + (TB_VERIFY ? n * (lat + 3) : 0);
        rst = 1'b0;
        cyc = 0;
        seen = 1'b0;
        bad = 1'b0;
        while (!seen && cyc < exp_cyc + 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) seen = 1'b1;
            else if (cpu_rst !== 1'b1 || busy !== 1'b1) bad = 1'b1;
            if (chg && cyc == 3) romsiz = 16'($urandom);
        end
        chk({tag, "_done_cycle"}, cyc, exp_cyc);
        chk({tag, "_pre_done_flags"}, 32'(bad), 32'd0);
        chk({tag, "_cpu_rst_released"}, 32'(cpu_rst), 32'd0);
        chk({tag, "_busy_cleared"}, 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_write_count"}, wr_cnt - wr_base, n);
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        chk({tag, "_read_count"}, rd_cnt - rd_base, TB_VERIFY ? n : 0);
        chk({tag, "_err"}, 32'(err), 32'(TB_VERIFY && corrupt_en && n > 2));
        chk({tag, "_done_sticky"}, 32'(done), 32'd1);
    endtask

    task automatic run_copy(input string tag, input logic [15:0] size, input int unsigned lat,
                            input bit pat, input bit chg);
        int unsigned n;
        prep(size, lat, pat, n);
        finish_run(tag, n, lat, chg);
    endtask

    initial begin
        int unsigned n, guard;
        rst = 1'b1;
        romsiz = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");

        run_copy("size8", 16'h0008, 0, 1'b1, 1'b0);
        run_copy("size0", 16'h0000, 0, 1'b0, 1'b0);
        run_copy("size5_lat3", 16'h0005, 3, 1'b0, 1'b0);
        run_copy("sizeFFFF", 16'hFFFF, 0, 1'b0, 1'b0);
        run_copy("size1", 16'h0001, 1, 1'b0, 1'b1);

        // Abort during the wait of the third write, then a clean restart.
        prep(16'h0010, 3, 1'b0, n);
        rst = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (!((wr_cnt - wr_base) == 2 && mem_req && r_wait == 1) && guard < 200);
        chk("abort_reached_third_wait", 32'(guard < 200), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("abort");
        prep(16'h0010, 3, 1'b0, n);
        finish_run("restart", n, 3, 1'b0);

        corrupt_en = 1'b1;
        run_copy("corrupt", 16'h000A, 1, 1'b0, 1'b0);
        corrupt_en = 1'b0;

        noise_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            logic [15:0] sz;
            sz = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 40));
            run_copy($sformatf("rand%0d", r), sz, $urandom_range(0, 3), 1'b0, 1'b1);
        end
        noise_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/boot_copy_ctl.md
# boot_copy_ctl

Boot-image copy sequencer. After reset it walks the 16-bit boot ROM, writes each word into main RAM through a request/acknowledge write port, and holds the CPU core in reset until the copy finishes. It sits between the boot ROM (combinational, 8-bit word address), the RAM arbiter's boot master port and the core reset input.

## Interface
- DST_BASE, 16'h0000: RAM word address of the first copied word.
- MAX_WORDS, 256: upper limit on the word count. Must not exceed the ROM depth of 256.
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- rom_adr  out  8  boot ROM word address
- rom_dat  in  16  boot ROM data; combinational from rom_adr
- romsiz  in  16  boot image size in bytes, from the ROM
- mem_req  out  1  RAM access request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
- mem_adr  out  16  RAM word address
- mem_wdat  out  16  RAM write data
- mem_ack  in  1  RAM accepted or completed the access this cycle
- mem_rdat  in  16  RAM read data; valid when mem_ack=1 on a read (used only with the verify macro)
- cpu_rst  out  1  core reset; high until the copy is done
- busy  out  1  copy or verify in progress
- done  out  1  sticky completion flag
- err  out  1  sticky verify-mismatch flag

## Operation
- Reset values: rom_adr=0, mem_req=0, mem_we=0, mem_adr=DST_BASE, mem_wdat=0, cpu_rst=1, busy=0, done=0, err=0. The FSM goes to IDLE.
- States and transitions:
  - IDLE → SIZE on the first cycle with rst=0.
  - SIZE latches the word count n = min(ceil(romsiz/2), MAX_WORDS) and clears the index i. If n=0 it goes to DONE; otherwise it goes to RD.
  - RD drives rom_adr=i and registers rom_dat into mem_wdat, then goes to WR.
  - WR asserts mem_req=1, mem_we=1, mem_adr=DST_BASE+i. It holds these until mem_ack=1. On the ack it increments i, deasserts mem_req the next cycle, and goes to RD if i<n, otherwise to DONE (or to VRD when the verify macro is defined).
  - DONE sets done=1, cpu_rst=0, busy=0, and stays there until rst.
- busy=1 in every state except IDLE and DONE.
- Index i is 9 bits so that n=256 terminates without wrap-around. rom_adr=i[7:0].
- mem_adr wraps modulo 2^16 if DST_BASE+i overflows. No error is raised for this.
- mem_wdat, mem_adr and mem_we must stay stable while mem_req=1 and mem_ack=0.
- mem_ack is ignored while mem_req=0.
- An odd romsiz rounds up: the last word is copied in full.
- romsiz is sampled once, in SIZE. Later changes to romsiz are ignored.
- rst=1 in any state, including mid-handshake, aborts the sequence on the next edge: mem_req drops, cpu_rst=1, done=0, err=0. A full copy restarts after rst is released. The RAM side must tolerate a dropped request.

## Timing
- Per word: 1 cycle in RD plus k≥1 cycles in WR, where k is the cycle on which mem_ack is first seen high.
- With mem_ack tied high, total copy time = 2 + 2n cycles from rst deassert to done=1. This is 2 + 2n + 3n cycles with verify enabled and ack tied high.
- done=1 and cpu_rst=0 change on the same edge. cpu_rst falls exactly one cycle after the last write ack (or last verify ack).
- Outputs are all registered. The only combinational path is rom_dat → mem_wdat register input.

## Configuration
- BOOT_COPY_VERIFY_EN defined:
  - After the last write the FSM runs a read-back pass through VRD → VCMP for each i = 0..n-1.
  - VRD issues mem_req=1, mem_we=0, mem_adr=DST_BASE+i and waits for mem_ack, capturing mem_rdat.
  - VCMP compares the captured data with rom_dat at rom_adr=i. A mismatch sets err=1, which is sticky.
  - The pass always completes all n words, then goes to DONE.
  - cpu_rst is still released when err=1; software reads err.
- BOOT_COPY_VERIFY_EN undefined:
  - There is no read-back pass, and mem_we=1 whenever mem_req=1.
  - err is tied to 0 and mem_rdat is unused.

## Test plan
- romsiz=16'h0008, ROM word k = 16'hA500+k, mem_ack tied high → 4 writes: adr 0..3 with data A500..A503; done=1 and cpu_rst=0 at cycle 10 after rst deassert.
- romsiz=16'h0000 → no mem_req ever asserted; done=1 and cpu_rst=0 at cycle 2.
- romsiz=16'h0005, DST_BASE=16'h1000, mem_ack delayed 3 cycles per request → 3 writes to adr 1000..1002; mem_adr and mem_wdat held stable through each wait.
- romsiz=16'hFFFF → exactly 256 writes, the last to adr DST_BASE+255; no wrap back to ROM address 0.
- rst pulsed for 1 cycle during the 3rd write's wait → mem_req=0 and cpu_rst=1 on the next edge; the copy restarts from word 0 and completes normally.
- With BOOT_COPY_VERIFY_EN defined, the RAM model corrupts word 2 on read-back → err=1 and done=1; all n verify reads are issued.
